// File: rtl/spi_accel_responder_if.sv
// SPI pins plus sample and write-report sideband between an initiator
// and the accelerometer responder.
interface spi_accel_responder_if;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic [15:0] y_sample;
    logic [15:0] z_sample;
    logic        sample_valid;
    logic        busy;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output SCLK, CS, MOSI, y_sample, z_sample, sample_valid,
        input  MISO, busy, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  SCLK, CS, MOSI, y_sample, z_sample, sample_valid,
        output MISO, busy, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_accel_responder.sv
// Mode-0 SPI responder that stands in for the accelerometer: 0x0B read / 0x0A write, register map, Y/Z shadow.
// Latency: SYNC_STAGES+1 clk from any pin edge to the resulting register or MISO update.
// Backpressure: none; the initiator paces everything through SCLK and must respect the minimum SCLK phase.
module spi_accel_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hAD
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_accel_responder_if.slave bus
);
    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic armed;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sh;
    logic [7:0]  rx_byte;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [6:0]  tx_sh;
    logic        miso_q;
    logic [7:0]  rd_byte;
    logic        ram_we;

    logic [7:0]  ram [16];
    logic [15:0] y_sh, z_sh;
    logic [15:0] y_pend, z_pend;
    logic        pending;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // armed only after a genuine CS-high has travelled through the synchronizer,
    // so a transaction cut by reset is not mistaken for a fresh CS fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            settle    <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            armed     <= armed | (settle[SYNC_STAGES-1] & cs_s);
        end
    end

    assign cs_fall   = armed & cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~cs_s & sclk_s & ~sclk_d;
    assign sclk_fall = ~cs_s & ~sclk_s & sclk_d;
    assign rx_byte   = {rx_sh, mosi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_rise) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cs_fall) state_nx = S_CMD;
                S_CMD:  if (sclk_rise && bit_cnt == 3'd7) state_nx = S_ADDR;
                S_ADDR: begin
                    if (sclk_rise && bit_cnt == 3'd7) begin
                        if (cmd == CMD_READ)       state_nx = S_READ;
                        else if (cmd == CMD_WRITE) state_nx = S_WRITE;
                        else                       state_nx = S_IGNORE;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            8'h00:   rd_byte = DEVID;
            8'h01:   rd_byte = 8'h1D;
            8'h02:   rd_byte = 8'hF2;
            8'h10:   rd_byte = y_sh[7:0];
            8'h11:   rd_byte = y_sh[15:8];
            8'h12:   rd_byte = z_sh[7:0];
            8'h13:   rd_byte = z_sh[15:8];
            default: if (addr[7:4] == 4'h2) rd_byte = ram[addr[3:0]];
        endcase
    end

    assign ram_we = sclk_rise && (state == S_WRITE) && (bit_cnt == 3'd7) && (addr[7:4] == 4'h2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            rx_sh    <= 7'd0;
            cmd      <= 8'h00;
            addr     <= 8'h00;
            tx_sh    <= 7'd0;
            miso_q   <= 1'b0;
            bus.wr_valid <= 1'b0;
            bus.wr_addr  <= 8'h00;
            bus.wr_data  <= 8'h00;
        end else begin
            bus.wr_valid <= 1'b0;
            if (cs_rise || cs_fall) begin
                bit_cnt <= 3'd0;
                miso_q  <= 1'b0;
            end else begin
                if (sclk_rise && state inside {S_CMD, S_ADDR, S_READ, S_WRITE}) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sh   <= rx_byte[6:0];
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            S_CMD:  cmd  <= rx_byte;
                            S_ADDR: addr <= rx_byte;
                            S_WRITE: begin
                                bus.wr_valid <= 1'b1;
                                bus.wr_addr  <= addr;
                                bus.wr_data  <= rx_byte;
                                addr         <= addr + 8'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                // The falling edge that opens each data byte loads the next register.
                if (sclk_fall && state == S_READ) begin
                    if (bit_cnt == 3'd0) begin
                        miso_q <= rd_byte[7];
                        tx_sh  <= rd_byte[6:0];
                        addr   <= addr + 8'd1;
                    end else begin
                        miso_q <= tx_sh[6];
                        tx_sh  <= {tx_sh[5:0], 1'b0};
                    end
                end
            end
        end
    end

    // Samples arriving mid-transaction wait for CS high so a burst never mixes two samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
            y_sh    <= 16'h0000;
            z_sh    <= 16'h0000;
            y_pend  <= 16'h0000;
            z_pend  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (ram_we) ram[addr[3:0]] <= rx_byte;
            if (bus.sample_valid && !cs_s) begin
                y_pend  <= bus.y_sample;
                z_pend  <= bus.z_sample;
                pending <= 1'b1;
            end else if (cs_s) begin
                if (bus.sample_valid) begin
                    y_sh <= bus.y_sample;
                    z_sh <= bus.z_sample;
                end else if (pending) begin
                    y_sh <= y_pend;
                    z_sh <= z_pend;
                end
                pending <= 1'b0;
            end
        end
    end

    assign bus.MISO = miso_q;
    assign bus.busy = ~cs_s;
endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: drives SPI transactions as an initiator and checks MISO bytes and write reports.
module tb_spi_accel_responder;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_hi = 0;
    int   wr_rise = 0;
    logic wr_prev = 1'b0;
    logic [15:0] wr_log[$];
    logic [7:0]  rdbuf [8];
    logic [7:0]  rx;
    logic [7:0]  acc;
    int          base;

    spi_accel_responder_if bus ();

    spi_accel_responder #(.SYNC_STAGES(2), .DEVID(8'hAD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            wr_hi++;
            wr_log.push_back({bus.wr_addr, bus.wr_data});
            if (!wr_prev) wr_rise++;
        end
        wr_prev = (bus.wr_valid === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = tx[7-i];
            repeat (HALF) @(negedge clk);
            r = {r[6:0], bus.MISO};
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic cs_begin();
        bus.CS = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        bus.CS = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a, input int nb);
        logic [7:0] r;
        cs_begin();
        spi_bits(8'h0B, 8, r);
        spi_bits(a, 8, r);
        for (int k = 0; k < nb; k++) begin
            spi_bits(8'h00, 8, r);
            rdbuf[k] = r;
        end
        cs_end();
    endtask

    task automatic wr2(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] r;
        cs_begin();
        spi_bits(8'h0A, 8, r);
        spi_bits(a, 8, r);
        spi_bits(d0, 8, r);
        spi_bits(d1, 8, r);
        cs_end();
    endtask

    task automatic strobe(input logic [15:0] y, input logic [15:0] z);
        bus.y_sample = y;
        bus.z_sample = z;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.SCLK = 1'b0;
        bus.CS = 1'b1;
        bus.MOSI = 1'b0;
        bus.y_sample = 16'h0000;
        bus.z_sample = 16'h0000;
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso", bus.MISO, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_wr_valid", bus.wr_valid, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, 8'h00);
        chk("rst_wr_data", bus.wr_data, 8'h00);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Read ID; command and address phases must see MISO at 0
        cs_begin();
        chk("busy_in_txn", bus.busy, 1'b1);
        spi_bits(8'h0B, 8, rx);
        chk("id_cmd_phase_miso", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        chk("id_addr_phase_miso", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        chk("read_devid", rx, 8'hAD);
        cs_end();
        chk("busy_after_txn", bus.busy, 1'b0);

        // Shadow burst with sample loaded while CS is high
        strobe(16'h1234, 16'hABCD);
        repeat (4) @(negedge clk);
        rd(8'h10, 4);
        chk("burst_y_lo", rdbuf[0], 8'h34);
        chk("burst_y_hi", rdbuf[1], 8'h12);
        chk("burst_z_lo", rdbuf[2], 8'hCD);
        chk("burst_z_hi", rdbuf[3], 8'hAB);

        // Constant registers
        rd(8'h01, 2);
        chk("reg01", rdbuf[0], 8'h1D);
        chk("reg02", rdbuf[1], 8'hF2);

        // Write two RAM bytes and read them back
        base = wr_log.size();
        wr2(8'h20, 8'h5A, 8'hC3);
        chk("wr_count", wr_log.size(), base + 2);
        chk("wr_first", wr_log[base], 16'h205A);
        chk("wr_second", wr_log[base+1], 16'h21C3);
        chk("wr_addr_hold", bus.wr_addr, 8'h21);
        chk("wr_data_hold", bus.wr_data, 8'hC3);
        rd(8'h20, 2);
        chk("ram20", rdbuf[0], 8'h5A);
        chk("ram21", rdbuf[1], 8'hC3);

        // Write to read-only DEVID is reported but not stored
        base = wr_log.size();
        cs_begin();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'hFF, 8, rx);
        cs_end();
        chk("wr_ro_count", wr_log.size(), base + 1);
        chk("wr_ro_report", wr_log[base], 16'h00FF);
        rd(8'h00, 1);
        chk("devid_protected", rdbuf[0], 8'hAD);

        // RAM top boundary: 0x2F stores, 0x30 does not
        wr2(8'h2F, 8'h77, 8'h88);
        rd(8'h2F, 2);
        chk("ram2f", rdbuf[0], 8'h77);
        chk("reg30_unmapped", rdbuf[1], 8'h00);

        // Address wrap 0xFF -> 0x00
        rd(8'hFF, 2);
        chk("regff", rdbuf[0], 8'h00);
        chk("wrap_to_devid", rdbuf[1], 8'hAD);

        // Unknown command: MISO stays low throughout
        acc = 8'h00;
        cs_begin();
        spi_bits(8'h55, 8, rx); acc |= rx;
        spi_bits(8'h00, 8, rx); acc |= rx;
        spi_bits(8'h00, 8, rx); acc |= rx;
        spi_bits(8'hFF, 8, rx); acc |= rx;
        cs_end();
        chk("ignore_miso", acc, 8'h00);

        // Sample arriving mid-burst is deferred until CS rises
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h10, 8, rx);
        strobe(16'h0BAD, 16'hABCD);
        spi_bits(8'h00, 8, rx);
        chk("defer_old_y_lo", rx, 8'h34);
        spi_bits(8'h00, 8, rx);
        chk("defer_old_y_hi", rx, 8'h12);
        cs_end();
        rd(8'h10, 2);
        chk("defer_new_y_lo", rdbuf[0], 8'hAD);
        chk("defer_new_y_hi", rdbuf[1], 8'h0B);

        // CS rise mid-data-byte drops the partial write
        base = wr_log.size();
        cs_begin();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'hFF, 4, rx);
        cs_end();
        chk("abort_no_wr", wr_log.size(), base);
        rd(8'h20, 1);
        chk("abort_ram_kept", rdbuf[0], 8'h5A);

        // Reset mid-read, then the rest of that CS-low period is ignored
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 4, rx);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_miso", bus.MISO, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_wr_valid", bus.wr_valid, 1'b0);
        chk("mid_rst_wr_addr", bus.wr_addr, 8'h00);
        chk("mid_rst_wr_data", bus.wr_data, 8'h00);
        reset = 1'b0;
        base = wr_log.size();
        acc = 8'h00;
        spi_bits(8'h00, 4, rx); acc |= rx;
        spi_bits(8'h0A, 8, rx); acc |= rx;
        spi_bits(8'h20, 8, rx); acc |= rx;
        spi_bits(8'hEE, 8, rx); acc |= rx;
        cs_end();
        chk("post_rst_ignored_miso", acc, 8'h00);
        chk("post_rst_no_wr", wr_log.size(), base);
        rd(8'h00, 1);
        chk("post_rst_devid", rdbuf[0], 8'hAD);
        rd(8'h20, 1);
        chk("post_rst_ram_cleared", rdbuf[0], 8'h00);
        rd(8'h10, 1);
        chk("post_rst_shadow_cleared", rdbuf[0], 8'h00);

        chk("wr_valid_one_clk", wr_hi, wr_rise);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
